// File: rtl/servant_wb_decoder.sv
// Wishbone 1-to-NS decoder for the SERV data bus: routes by the top SW address bits,
// acks unmapped regions with an error. Define SERVANT_WB_TIMEOUT_EN to add a bus watchdog.
module servant_wb_decoder #(
  parameter int unsigned     NS       = 4,
  parameter int unsigned     SW       = 2,
  parameter logic [NS-1:0]   AUTO_ACK = NS'(4'b1110),
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_wb_cpu_adr,
  input  logic [31:0]      i_wb_cpu_dat,
  input  logic [3:0]       i_wb_cpu_sel,
  input  logic             i_wb_cpu_we,
  input  logic             i_wb_cpu_cyc,
  output logic [31:0]      o_wb_cpu_rdt,
  output logic             o_wb_cpu_ack,
  output logic             o_wb_cpu_err,
  output logic [31:0]      o_wb_s_adr,
  output logic [31:0]      o_wb_s_dat,
  output logic [3:0]       o_wb_s_sel,
  output logic             o_wb_s_we,
  output logic [NS-1:0]    o_wb_s_cyc,
  input  logic [NS*32-1:0] i_wb_s_rdt,
  input  logic [NS-1:0]    i_wb_s_ack
);

  if (NS < 2 || NS > 16 || (1 << SW) < NS || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("servant_wb_decoder: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StActive, StResp} state_e;

  state_e          state_q;
  logic [SW-1:0]   idx_q;
  logic [NS-1:0]   cyc_q;
  logic            ack_q;
  logic            err_q;
  logic [31:0]     rdt_q;

  logic [SW-1:0]   req_idx;
  logic            req_mapped;
  logic [NS-1:0]   req_onehot;
  logic            sel_ack;
  logic [31:0]     sel_rdt;

`ifdef SERVANT_WB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  logic [15:0]     cnt_q;
`endif

  assign o_wb_s_adr = i_wb_cpu_adr;
  assign o_wb_s_dat = i_wb_cpu_dat;
  assign o_wb_s_sel = i_wb_cpu_sel;
  assign o_wb_s_we  = i_wb_cpu_we;

  assign req_idx    = i_wb_cpu_adr[31:32-SW];
  assign req_mapped = 32'(req_idx) < NS;

  // Decode the incoming address, and mux the ack/data of the latched slave.
  always_comb begin
    req_onehot = '0;
    sel_ack    = 1'b0;
    sel_rdt    = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (32'(req_idx) == k) req_onehot[k] = 1'b1;
      if (32'(idx_q) == k) begin
        sel_ack = AUTO_ACK[k] | i_wb_s_ack[k];
        sel_rdt = i_wb_s_rdt[32*k +: 32];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cyc_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdt_q   <= '0;
`ifdef SERVANT_WB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (i_wb_cpu_cyc) begin
            idx_q <= req_idx;
            if (req_mapped) begin
              state_q <= StActive;
              cyc_q   <= req_onehot;
`ifdef SERVANT_WB_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              state_q <= StResp;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdt_q   <= '0;
            end
          end
        end
        StActive: begin
          // Abort takes priority over a same-cycle slave ack.
          if (!i_wb_cpu_cyc) begin
            state_q <= StIdle;
            cyc_q   <= '0;
          end else if (sel_ack) begin
            state_q <= StResp;
            cyc_q   <= '0;
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
            rdt_q   <= sel_rdt;
          end
`ifdef SERVANT_WB_TIMEOUT_EN
          else if (cnt_q == TimeoutLast) begin
            state_q <= StResp;
            cyc_q   <= '0;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdt_q   <= 32'hDEADBEEF;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        StResp: begin
          state_q <= StIdle;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          cyc_q   <= '0;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_wb_s_cyc   = cyc_q;
  assign o_wb_cpu_ack = ack_q;
  assign o_wb_cpu_err = err_q;
  assign o_wb_cpu_rdt = rdt_q;

endmodule

// File: tb/tb_servant_wb_decoder.sv
// Scoreboard bench for servant_wb_decoder: a default NS=4 instance and an NS=3 instance
// with an unmapped top region; expected acks are queued by stimulus and popped by a monitor.
module tb_servant_wb_decoder;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rdt;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc_cnt = 0;
  int n_chk = 0;
  int n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] exp_last_rdt = '0;
  logic [3:0]  strobe_acc = '0;

  // Instance A: NS=4, SW=2, AUTO_ACK=4'b1110, TIMEOUT=8
  logic [31:0]  a_adr = '0, a_dat = '0;
  logic [3:0]   a_sel = '0;
  logic         a_we = 1'b0, a_cyc = 1'b0;
  logic [31:0]  a_rdt;
  logic         a_ack, a_err;
  logic [31:0]  a_s_adr, a_s_dat;
  logic [3:0]   a_s_sel;
  logic         a_s_we;
  logic [3:0]   a_s_cyc;
  logic [127:0] a_s_rdt = '0;
  logic [3:0]   a_s_ack = '0;

  // Instance B: NS=3, region 3 unmapped
  logic [31:0]  b_adr = '0;
  logic         b_cyc = 1'b0;
  logic [31:0]  b_rdt;
  logic         b_ack, b_err;
  logic [31:0]  b_s_adr, b_s_dat;
  logic [3:0]   b_s_sel;
  logic         b_s_we;
  logic [2:0]   b_s_cyc;
  logic [95:0]  b_s_rdt = '0;
  logic [2:0]   b_s_ack = '0;

  servant_wb_decoder #(.NS(4), .SW(2), .AUTO_ACK(4'b1110), .TIMEOUT(8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cpu_adr(a_adr), .i_wb_cpu_dat(a_dat), .i_wb_cpu_sel(a_sel),
    .i_wb_cpu_we(a_we), .i_wb_cpu_cyc(a_cyc),
    .o_wb_cpu_rdt(a_rdt), .o_wb_cpu_ack(a_ack), .o_wb_cpu_err(a_err),
    .o_wb_s_adr(a_s_adr), .o_wb_s_dat(a_s_dat), .o_wb_s_sel(a_s_sel), .o_wb_s_we(a_s_we),
    .o_wb_s_cyc(a_s_cyc), .i_wb_s_rdt(a_s_rdt), .i_wb_s_ack(a_s_ack)
  );

  servant_wb_decoder #(.NS(3), .SW(2), .AUTO_ACK(3'b110), .TIMEOUT(8)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cpu_adr(b_adr), .i_wb_cpu_dat(32'h0), .i_wb_cpu_sel(4'hF),
    .i_wb_cpu_we(1'b0), .i_wb_cpu_cyc(b_cyc),
    .o_wb_cpu_rdt(b_rdt), .o_wb_cpu_ack(b_ack), .o_wb_cpu_err(b_err),
    .o_wb_s_adr(b_s_adr), .o_wb_s_dat(b_s_dat), .o_wb_s_sel(b_s_sel), .o_wb_s_we(b_s_we),
    .o_wb_s_cyc(b_s_cyc), .i_wb_s_rdt(b_s_rdt), .i_wb_s_ack(b_s_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int unsigned c, input logic [31:0] r, input logic e);
    exp_t x;
    x.cyc = c;
    x.rdt = r;
    x.err = e;
    return x;
  endfunction

  // Monitor: pops one expectation per observed ack pulse
  always @(negedge clk) begin
    if (rst_n) begin
      strobe_acc = strobe_acc | a_s_cyc;
      if (a_ack) begin
        if (qa.size() == 0) begin
          check("a_unexpected_ack", 32'(a_ack), 32'd0);
        end else begin
          exp_t e;
          e = qa.pop_front();
          check("a_ack_cycle", cyc_cnt, e.cyc);
          check("a_rdt", a_rdt, e.rdt);
          check("a_err", 32'(a_err), 32'(e.err));
        end
      end
      if (b_ack) begin
        if (qb.size() == 0) begin
          check("b_unexpected_ack", 32'(b_ack), 32'd0);
        end else begin
          exp_t e;
          e = qb.pop_front();
          check("b_ack_cycle", cyc_cnt, e.cyc);
          check("b_rdt", b_rdt, e.rdt);
          check("b_err", 32'(b_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    int unsigned start;

    // Reset state
    tick();
    tick();
    check("rst_ack", 32'(a_ack), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_rdt", a_rdt, 32'd0);
    check("rst_cyc", 32'(a_s_cyc), 32'd0);
    rst_n = 1'b1;
    tick();

    // Read slave0 which acks 3 cycles after its strobe
    strobe_acc = '0;
    a_s_rdt[31:0] = 32'h1234_5678;
    start = cyc_cnt;
    a_adr = 32'h0000_0010; a_we = 1'b0; a_sel = 4'hF; a_cyc = 1'b1;
    qa.push_back(mk(start + 5, 32'h1234_5678, 1'b0));
    exp_last_rdt = 32'h1234_5678;
    tick();
    check("t1_strobe_c1", 32'(a_s_cyc), 32'h1);
    tick(); tick(); tick();
    a_s_ack[0] = 1'b1;
    tick();
    a_s_ack[0] = 1'b0;
    check("t1_strobe_resp", 32'(a_s_cyc), 32'h0);
    a_cyc = 1'b0;
    tick();
    check("t1_only_slave0", 32'(strobe_acc), 32'h1);

    // Write to auto-acked slave1
    a_s_rdt[63:32] = 32'hA5A5_0001;
    start = cyc_cnt;
    a_adr = 32'h4000_0000; a_dat = 32'h1; a_we = 1'b1; a_cyc = 1'b1;
    qa.push_back(mk(start + 2, 32'hA5A5_0001, 1'b0));
    exp_last_rdt = 32'hA5A5_0001;
    tick();
    check("t2_strobe_c1", 32'(a_s_cyc), 32'h2);
    check("t2_we", 32'(a_s_we), 32'h1);
    check("t2_dat", a_s_dat, 32'h1);
    check("t2_adr", a_s_adr, 32'h4000_0000);
    tick();
    check("t2_strobe_c2", 32'(a_s_cyc), 32'h0);
    a_cyc = 1'b0; a_we = 1'b0;
    tick();

    // NS=3: mapped auto-ack slave1 then unmapped region 3
    b_s_rdt[63:32] = 32'h0BAD_F00D;
    start = cyc_cnt;
    b_adr = 32'h4000_0000; b_cyc = 1'b1;
    qb.push_back(mk(start + 2, 32'h0BAD_F00D, 1'b0));
    tick();
    check("t3_b_strobe", 32'(b_s_cyc), 32'h2);
    tick();
    b_cyc = 1'b0;
    tick();
    start = cyc_cnt;
    b_adr = 32'hC000_0000; b_cyc = 1'b1;
    qb.push_back(mk(start + 1, 32'h0, 1'b1));
    tick();
    check("t3_unmapped_strobe", 32'(b_s_cyc), 32'h0);
    b_cyc = 1'b0;
    tick();

    // Slave0 never acks
    start = cyc_cnt;
    a_adr = 32'h0000_0000; a_cyc = 1'b1;
`ifdef SERVANT_WB_TIMEOUT_EN
    qa.push_back(mk(start + 9, 32'hDEAD_BEEF, 1'b1));
    exp_last_rdt = 32'hDEAD_BEEF;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t4_strobe_wait", 32'(a_s_cyc), 32'h1);
    end
    tick();
    check("t4_strobe_resp", 32'(a_s_cyc), 32'h0);
    a_cyc = 1'b0;
    tick();
`else
    repeat (1000) tick();
    check("t4_still_waiting", 32'(a_s_cyc), 32'h1);
    a_cyc = 1'b0;
    tick();
    check("t4_abort_idle", 32'(a_s_cyc), 32'h0);
`endif

    // Abort at ACTIVE cycle 2 with a coincident slave ack
    a_s_rdt[31:0] = 32'h5555_5555;
    a_adr = 32'h0000_0000; a_cyc = 1'b1;
    tick();
    tick();
    a_cyc = 1'b0;
    a_s_ack[0] = 1'b1;
    tick();
    a_s_ack[0] = 1'b0;
    check("t5_abort_strobe", 32'(a_s_cyc), 32'h0);
    repeat (3) tick();
    check("t5_rdt_held", a_rdt, exp_last_rdt);

    // Asynchronous reset mid-ACTIVE
    a_cyc = 1'b1;
    tick();
    check("t6_strobe", 32'(a_s_cyc), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_cyc", 32'(a_s_cyc), 32'h0);
    check("t6_rst_ack", 32'(a_ack), 32'h0);
    check("t6_rst_err", 32'(a_err), 32'h0);
    check("t6_rst_rdt", a_rdt, 32'h0);
    a_cyc = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back: cyc held through ack with a new address
    a_s_rdt[63:32] = 32'h1111_2222;
    a_s_rdt[95:64] = 32'h3333_4444;
    start = cyc_cnt;
    a_adr = 32'h4000_0000; a_cyc = 1'b1;
    qa.push_back(mk(start + 2, 32'h1111_2222, 1'b0));
    qa.push_back(mk(start + 5, 32'h3333_4444, 1'b0));
    tick();
    check("t7_strobe_s1", 32'(a_s_cyc), 32'h2);
    tick();
    a_adr = 32'h8000_0000;
    tick();
    check("t7_idle_gap", 32'(a_s_cyc), 32'h0);
    tick();
    check("t7_strobe_s2", 32'(a_s_cyc), 32'h4);
    tick();
    a_cyc = 1'b0;
    tick();
    tick();

    check("qa_drained", qa.size(), 32'd0);
    check("qb_drained", qb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/servant_wb_decoder.md
# servant_wb_decoder

Parametrised Wishbone 1-to-N decoder that replaces the fixed four-region servant memory/GPIO/timer mux. It sits between the SERV CPU data bus and NS slave ports and routes each cycle by the top address bits. It adds a registered handshake state machine, per-slave real or automatic acknowledge, an error response for unmapped regions, and an optional bus-timeout watchdog.

## Interface
- NS, 4, number of slave ports (2..16)
- SW, 2, select-field width; region index = i_wb_cpu_adr[31:32-SW]; requires 2**SW >= NS
- AUTO_ACK, 4'b1110, bit k=1: slave k has no ack output, so the decoder acknowledges it itself
- TIMEOUT, 255, ACTIVE cycles before watchdog error (1..65535); used only with the watchdog compiled in
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wb_cpu_adr  in  32  CPU address
- i_wb_cpu_dat  in  32  CPU write data
- i_wb_cpu_sel  in  4  byte selects
- i_wb_cpu_we  in  1  write enable
- i_wb_cpu_cyc  in  1  cycle request, held by the CPU until ack
- o_wb_cpu_rdt  out  32  registered read data
- o_wb_cpu_ack  out  1  one-cycle acknowledge pulse
- o_wb_cpu_err  out  1  qualifies ack as an error; valid only while ack=1
- o_wb_s_adr  out  32  shared address, i_wb_cpu_adr passed through
- o_wb_s_dat  out  32  shared write data, passed through
- o_wb_s_sel  out  4  shared byte selects, passed through
- o_wb_s_we  out  1  shared write enable, passed through
- o_wb_s_cyc  out  NS  per-slave cycle strobe
- i_wb_s_rdt  in  NS*32  slave k read data on bits [32k+31:32k]
- i_wb_s_ack  in  NS  slave acks; bits set in AUTO_ACK are ignored

## Operation
- States: IDLE, ACTIVE, RESP.
- IDLE, with i_wb_cpu_cyc=1:
  - Latch idx = adr[31:32-SW].
  - idx < NS: go to ACTIVE.
  - idx >= NS (unmapped): go to RESP with err=1 and rdt=0.
- ACTIVE:
  - o_wb_s_cyc[idx]=1; all other strobes stay 0.
  - Completes when AUTO_ACK[idx]=1 (first ACTIVE cycle) or when i_wb_s_ack[idx]=1.
  - On completion: register rdt<=i_wb_s_rdt[idx] (reads and writes alike), err<=0, go to RESP.
- RESP:
  - o_wb_cpu_ack=1 for exactly one cycle; all slave strobes are 0.
  - Next state is always IDLE, so a new request is sampled at the earliest one cycle after ack.
- Abort: if i_wb_cpu_cyc drops while in ACTIVE, go to IDLE next cycle. No ack, rdt unchanged.
- Only the latched idx is used once ACTIVE; address changes during ACTIVE do not reroute.
- o_wb_cpu_rdt holds its value between transactions.
- Reset (any state, asynchronous):
  - State goes to IDLE.
  - o_wb_cpu_ack=0, o_wb_cpu_err=0, o_wb_cpu_rdt=0, o_wb_s_cyc=0.
  - Timeout counter cleared.
  - An in-flight transaction is dropped with no ack.

## Timing
- Cycle 0: cyc rises (IDLE).
- Cycle 1: ACTIVE, slave strobe high.
- Auto-ack slave: ack at cycle 2.
- Slave acking at cycle n (n>=1): ack at n+1.
- Unmapped region: err ack at cycle 1.
- Slave ack and abort in the same cycle: abort wins, no ack.
- Slave ack and timeout expiry in the same cycle: slave ack wins, err=0.
- Pass-through signals are combinational; cyc strobes, ack, err and rdt are registered.

## Configuration
- SERVANT_WB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When the count reaches TIMEOUT with no completion, go to RESP with err=1 and rdt=32'hDEADBEEF. Strobe cyc drops with the ack.
- SERVANT_WB_TIMEOUT_EN undefined:
  - No counter; ACTIVE waits indefinitely for the slave ack.
  - TIMEOUT is unused. The unmapped-region error is still generated.

## Test plan
- NS=4 defaults; read adr 32'h0000_0010, slave0 acks 3 cycles after its strobe with rdt 32'h1234_5678 -> o_wb_cpu_ack one cycle after slave ack, rdt=32'h1234_5678, err=0, only o_wb_s_cyc[0] ever high.
- Write adr 32'h4000_0000 dat 1 (slave1, AUTO_ACK) -> o_wb_s_cyc[1] high at cycle 1 only, ack at cycle 2, we/dat seen on shared bus.
- NS=3, SW=2; access adr 32'hC000_0000 -> ack+err at cycle 1, rdt=0, no slave strobe.
- With SERVANT_WB_TIMEOUT_EN and TIMEOUT=8; slave0 never acks -> ack+err after 8 ACTIVE cycles, rdt=32'hDEADBEEF, strobe low in RESP. Without the macro -> no ack after 1000 cycles.
- Drop cyc at ACTIVE cycle 2 -> IDLE next cycle, no ack. Assert i_rst_n=0 mid-ACTIVE -> all outputs 0 immediately.
- Back-to-back: the CPU holds cyc through ack with a new address -> second transaction starts in the IDLE cycle after RESP and routes to the new slave.
